// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED PWM display block.
//   LED_W     : number of board LEDs driven by the block
//   state_t   : handshake / hold state machine states
//   LED_DARK  : level that turns every LED off
//   to_drive(): maps a lit pattern (1 = lit) onto the board drive polarity
// Configuration macro: LED_ACTIVE_LOW_EN
//   defined   -> LEDs are lit by driving 0, dark level is all ones
//   undefined -> LEDs are lit by driving 1, dark level is all zeros
// ---------------------------------------------------------------------------
package led_pkg;

  localparam int LED_W = 6;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [LED_W-1:0] LED_DARK = {LED_W{1'b1}};
`else
  localparam logic [LED_W-1:0] LED_DARK = {LED_W{1'b0}};
`endif

  // XOR with the dark level flips the pattern only for active-low boards.
  function automatic logic [LED_W-1:0] to_drive(input logic [LED_W-1:0] lit);
    return lit ^ LED_DARK;
  endfunction

endpackage

// File: rtl/led_pwm_display_pwm_gen.sv
// ---------------------------------------------------------------------------
// pwm_gen
// Free-running PWM counter with a single brightness enable output.
//   clk_4_5 : clock, rising edge
//   reset   : asynchronous active-high reset, counter returns to 0
//   pwm_en  : high while the counter is below DUTY
// Parameters:
//   PWM_BITS : counter width, period is 2^PWM_BITS cycles
//   DUTY     : lit cycles per period (0 .. 2^PWM_BITS)
// ---------------------------------------------------------------------------
module pwm_gen #(
  parameter int                PWM_BITS = 4,
  parameter logic [PWM_BITS:0] DUTY     = 4
) (
  input  logic clk_4_5,
  input  logic reset,
  output logic pwm_en
);

  logic [PWM_BITS-1:0] pwm_cnt;

  // The counter is never restarted by traffic, so brightness stays
  // steady regardless of how often the pattern changes.
  always_ff @(posedge clk_4_5 or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Compare one bit wider than the counter so DUTY = 2^PWM_BITS is
  // always true and DUTY = 0 is always false.
  assign pwm_en = ({1'b0, pwm_cnt} < DUTY);

endmodule

// File: rtl/led_pwm_display.sv
// ---------------------------------------------------------------------------
// led_pwm_display
// Accepts a 6-bit LED pattern over a valid/ready handshake, then refuses
// further updates for HOLD_CYCLES cycles, and shows the stored pattern on
// the board LEDs dimmed by a free-running PWM.
// Ports:
//   clk_4_5    : clock, rising edge
//   reset      : asynchronous active-high reset
//   data_in    : LED pattern from the upstream stage
//   data_valid : data_in is valid this cycle
//   data_ready : block accepts data_in this cycle (registered)
//   leds       : PWM-modulated pattern to the board LEDs (registered)
// Parameters: PWM_BITS, DUTY (passed to pwm_gen), HOLD_CYCLES (1..65535)
// Configuration macro: LED_ACTIVE_LOW_EN (selects LED drive polarity)
// ---------------------------------------------------------------------------
module led_pwm_display
  import led_pkg::*;
#(
  parameter int                PWM_BITS    = 4,
  parameter logic [PWM_BITS:0] DUTY        = 4,
  parameter int                HOLD_CYCLES = 16
) (
  input  logic             clk_4_5,
  input  logic             reset,
  input  logic [LED_W-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [LED_W-1:0] leds
);

  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES);

  state_t           state;
  state_t           state_next;
  logic [15:0]      hold_cnt;
  logic [15:0]      hold_cnt_next;
  logic [LED_W-1:0] pattern;
  logic             pwm_en;
  logic             transfer;

  pwm_gen #(
    .PWM_BITS (PWM_BITS),
    .DUTY     (DUTY)
  ) u_pwm_gen (
    .clk_4_5 (clk_4_5),
    .reset   (reset),
    .pwm_en  (pwm_en)
  );

  assign transfer = data_valid & data_ready;

  // State and hold counter registers.
  always_ff @(posedge clk_4_5 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_cnt_next;
    end
  end

  // Leave HOLD on the edge where the counter hits 0; together with the
  // registered ready decode this keeps ready low for exactly HOLD_CYCLES.
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    case (state)
      IDLE: begin
        if (transfer) begin
          state_next    = HOLD;
          hold_cnt_next = HOLD_LOAD;
        end
      end
      HOLD: begin
        hold_cnt_next = hold_cnt - 16'd1;
        if (hold_cnt <= 16'd1) begin
          state_next    = IDLE;
          hold_cnt_next = '0;
        end
      end
      default: begin
        state_next    = IDLE;
        hold_cnt_next = '0;
      end
    endcase
  end

  // Ready is decoded from the next state so it is a clean flop output;
  // reset holds it low so nothing is accepted before the first edge.
  always_ff @(posedge clk_4_5 or posedge reset) begin
    if (reset) begin
      data_ready <= 1'b0;
    end else begin
      data_ready <= (state_next == IDLE);
    end
  end

  // Pattern only changes as a whole word on an accepted transfer.
  always_ff @(posedge clk_4_5 or posedge reset) begin
    if (reset) begin
      pattern <= '0;
    end else if (transfer) begin
      pattern <= data_in;
    end
  end

  // Output register: gated pattern mapped to board polarity. A cleared
  // pattern naturally yields the dark level until the first transfer.
  always_ff @(posedge clk_4_5 or posedge reset) begin
    if (reset) begin
      leds <= LED_DARK;
    end else begin
      leds <= to_drive(pattern & {LED_W{pwm_en}});
    end
  end

endmodule

// File: tb/tb_led_pwm_display.sv
// ---------------------------------------------------------------------------
// tb_led_pwm_display
// Self-checking bench for led_pwm_display. Three instances share stimulus
// and differ only in DUTY (4, 0, 16). A timestamp-based reference model
// predicts ready and LED values every cycle.
// Honours LED_ACTIVE_LOW_EN for the expected dark level.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_led_pwm_display;

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [5:0] DARK = 6'h3F;
`else
  localparam logic [5:0] DARK = 6'h00;
`endif
  localparam int HOLD = 16;
  localparam int PERIOD = 16;

  logic       clk_4_5 = 1'b0;
  logic       reset;
  logic       data_valid;
  logic [5:0] data_in;
  logic       ready_a, ready_b, ready_c;
  logic [5:0] leds_a, leds_b, leds_c;

  always #5 clk_4_5 = ~clk_4_5;

  led_pwm_display #(.PWM_BITS(4), .DUTY(5'd4), .HOLD_CYCLES(HOLD)) dut (
    .clk_4_5(clk_4_5), .reset(reset), .data_in(data_in),
    .data_valid(data_valid), .data_ready(ready_a), .leds(leds_a));

  led_pwm_display #(.PWM_BITS(4), .DUTY(5'd0), .HOLD_CYCLES(HOLD)) dut_dark (
    .clk_4_5(clk_4_5), .reset(reset), .data_in(data_in),
    .data_valid(data_valid), .data_ready(ready_b), .leds(leds_b));

  led_pwm_display #(.PWM_BITS(4), .DUTY(5'd16), .HOLD_CYCLES(HOLD)) dut_full (
    .clk_4_5(clk_4_5), .reset(reset), .data_in(data_in),
    .data_valid(data_valid), .data_ready(ready_c), .leds(leds_c));

  int compared = 0;
  int mismatched = 0;

  // Reference model state: edge count since reset release, stored
  // pattern, and the edge index from which ready is high.
  int         ref_k;
  int         ready_at;
  logic [5:0] ref_pat;
  logic       exp_ready;
  logic [5:0] exp_leds [3];
  int         duty_tab [3] = '{4, 0, 16};

  typedef struct {
    logic       dv;
    logic [5:0] din;
    logic       exp_ready;
    logic [5:0] exp_lit;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    check("ready duty4", {15'b0, ready_a}, {15'b0, exp_ready});
    check("ready duty0", {15'b0, ready_b}, {15'b0, exp_ready});
    check("ready duty16", {15'b0, ready_c}, {15'b0, exp_ready});
    check("leds duty4", {10'b0, leds_a}, {10'b0, exp_leds[0]});
    check("leds duty0", {10'b0, leds_b}, {10'b0, exp_leds[1]});
    check("leds duty16", {10'b0, leds_c}, {10'b0, exp_leds[2]});
  endtask

  task automatic model_reset();
    ref_k     = 0;
    ready_at  = 1;
    ref_pat   = 6'h00;
    exp_ready = 1'b0;
    for (int i = 0; i < 3; i++) exp_leds[i] = DARK;
  endtask

  // One clock: drive at negedge, advance model at posedge, compare 1ns later.
  task automatic apply_stimulus(input logic dv, input logic [5:0] din);
    @(negedge clk_4_5);
    data_valid = dv;
    data_in    = din;
    @(posedge clk_4_5);
    ref_k++;
    for (int i = 0; i < 3; i++)
      exp_leds[i] = ((((ref_k - 1) % PERIOD) < duty_tab[i]) ? ref_pat : 6'h00) ^ DARK;
    if (dv && ((ref_k - 1) >= ready_at)) begin
      ref_pat  = din;
      ready_at = ref_k + HOLD;
    end
    exp_ready = (ref_k >= ready_at);
    #1;
    check_output();
  endtask

  // Reset asserted away from any clock edge; outputs must go dark at once.
  task automatic pulse_reset();
    @(posedge clk_4_5);
    #3;
    reset = 1'b1;
    #1;
    check("async reset ready", {15'b0, ready_a}, 16'h0000);
    check("async reset leds", {10'b0, leds_a}, {10'b0, DARK});
    check("async reset leds duty16", {10'b0, leds_c}, {10'b0, DARK});
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    int low_cnt;
    bit done;

    vecs[0] = '{1'b1, 6'h2A, 1'b1, 6'h00};
    vecs[1] = '{1'b1, 6'h2A, 1'b0, 6'h00};
    vecs[2] = '{1'b0, 6'h00, 1'b0, 6'h2A};
    vecs[3] = '{1'b0, 6'h00, 1'b0, 6'h2A};
    vecs[4] = '{1'b0, 6'h00, 1'b0, 6'h00};
    vecs[5] = '{1'b1, 6'h15, 1'b0, 6'h00};

    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = 6'h00;
    model_reset();
    #12;
    check("reset ready", {15'b0, ready_a}, 16'h0000);
    check("reset leds", {10'b0, leds_a}, {10'b0, DARK});
    @(posedge clk_4_5);
    #4;
    reset = 1'b0;

    // Directed table right after reset release.
    for (int v = 0; v < 6; v++) begin
      apply_stimulus(vecs[v].dv, vecs[v].din);
      check("table ready", {15'b0, ready_a}, {15'b0, vecs[v].exp_ready});
      check("table leds", {10'b0, leds_a}, {10'b0, vecs[v].exp_lit ^ DARK});
    end

    // Held upstream request across a full hold window.
    pulse_reset();
    apply_stimulus(1'b1, 6'h2A);
    apply_stimulus(1'b1, 6'h2A);
    low_cnt = 0;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      if (ready_a) done = 1'b1;
      else begin
        low_cnt++;
        apply_stimulus(1'b1, 6'h15);
      end
    end
    check("hold low cycles", 16'(low_cnt), 16'(HOLD));
    apply_stimulus(1'b1, 6'h15);
    apply_stimulus(1'b0, 6'h00);
    check("held request shown", {10'b0, leds_a}, {10'b0, 6'h15 ^ DARK});
    check("held request full duty", {10'b0, leds_c}, {10'b0, 6'h15 ^ DARK});

    // Reset in the middle of a hold (counter at 7).
    pulse_reset();
    apply_stimulus(1'b1, 6'h2A);
    apply_stimulus(1'b1, 6'h2A);
    for (int n = 0; n < 9; n++) apply_stimulus(1'b0, 6'h00);
    pulse_reset();
    apply_stimulus(1'b0, 6'h00);
    check("ready after mid-hold reset", {15'b0, ready_a}, 16'h0001);
    apply_stimulus(1'b1, 6'h33);
    apply_stimulus(1'b0, 6'h00);
    check("pattern after mid-hold reset", {10'b0, leds_a}, {10'b0, 6'h33 ^ DARK});

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) pulse_reset();
      apply_stimulus($urandom_range(0, 3) != 0, 6'($urandom_range(0, 63)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
